ascon_ctrl_fsm: RTL and testbench



---
 rtl/ascon_pack.sv | 31 +++
 rtl/ascon_ctrl_fsm_round_counter.sv | 45 ++++
 rtl/ascon_ctrl_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_ascon_ctrl_fsm.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// ascon_pack
// Shared definitions for the Ascon-128 sequencing controller.
//   type_ctrl_state : controller state encoding
//   ROUND_A_FIRST   : first round of the 12-round permutation p^a
//   ROUND_B_FIRST   : first round of the 6-round permutation p^b
//   ROUND_LAST      : last round index of either permutation
//   isLastRound     : true when a round index is the final one
package ascon_pack;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_AD,
    AD,
    WAIT_PT,
    PT,
    FINAL,
    DONE
  } type_ctrl_state;

  localparam logic [3:0] ROUND_A_FIRST = 4'd0;
  localparam logic [3:0] ROUND_B_FIRST = 4'd6;
  localparam logic [3:0] ROUND_LAST    = 4'd11;

  // Both permutation flavours end on the same round index, so one test
  // serves every state that runs rounds.
  function automatic logic isLastRound(input logic [3:0] rnd);
    return rnd == ROUND_LAST;
  endfunction

endpackage

// File: rtl/ascon_ctrl_fsm_round_counter.sv
// round_counter
// 4-bit loadable round counter used by the Ascon controller.
//   clock_i     : system clock, rising edge
//   reset_i     : asynchronous active-high reset, clears the count
//   load_i      : load loadValue_i on the next edge (has priority)
//   loadValue_i : value to load
//   countEn_i   : increment on the next edge when not loading
//   rnd_o       : current round index
module round_counter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       load_i,
  input  logic [3:0] loadValue_i,
  input  logic       countEn_i,
  output logic [3:0] rnd_o
);

  logic [3:0] rnd_q;
  logic [3:0] rnd_d;

  // Load wins over counting so a state change can place the counter at the
  // first round of the next permutation in the same edge it leaves the last.
  always_comb begin
    rnd_d = rnd_q;
    if (load_i) begin
      rnd_d = loadValue_i;
    end else if (countEn_i) begin
      rnd_d = rnd_q + 4'd1;
    end
  end

  // Round register; reset returns it to the first round of p^a.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rnd_q <= ROUND_A_FIRST;
    end else begin
      rnd_q <= rnd_d;
    end
  end

  assign rnd_o = rnd_q;

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ascon_ctrl_fsm
// Sequencing controller for the Ascon-128 datapath: walks initialization,
// one associated-data block, NB_BLOCKS plaintext blocks and finalization,
// driving the permutation one round per cycle.
//   clock_i, reset_i  : clock (rising edge) and async active-high reset
//   start_i           : begin a message (honoured in IDLE or DONE only)
//   data_valid_i      : host offers the next AD/PT block
//   data_ready_o      : controller accepts a block this cycle
//   round_o           : round constant index to the permutation
//   selectionp_o      : 0 = load external initial state, 1 = feed back
//   enable_o          : state register enable
//   en_xor_data_b_o   : XOR data at permutation input
//   en_xor_key_b_o    : XOR key at permutation input
//   en_xor_key_e_o    : XOR key at permutation output
//   en_xor_lsb_e_o    : domain-separation XOR at permutation output
//   en_cipher_o       : capture cipher block
//   en_tag_o          : capture tag
//   block_o           : index of the current PT block
//   done_o            : message complete
module ascon_ctrl_fsm
  import ascon_pack::*;
#(
  parameter int NB_BLOCKS = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic [3:0] round_o,
  output logic       selectionp_o,
  output logic       enable_o,
  output logic       en_xor_data_b_o,
  output logic       en_xor_key_b_o,
  output logic       en_xor_key_e_o,
  output logic       en_xor_lsb_e_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic [3:0] block_o,
  output logic       done_o
);

  localparam logic [3:0] LAST_BLOCK = 4'(NB_BLOCKS - 1);

  type_ctrl_state state_q;
  type_ctrl_state state_d;
  logic [3:0]     blk_q;
  logic [3:0]     blk_d;

  logic [3:0] rnd;
  logic       rndLoad;
  logic [3:0] rndLoadValue;
  logic       rndCountEn;
  logic       lastRound;

  round_counter uRoundCounter (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .load_i      (rndLoad),
    .loadValue_i (rndLoadValue),
    .countEn_i   (rndCountEn),
    .rnd_o       (rnd)
  );

  assign lastRound = isLastRound(rnd);

  // State and block-index registers. Reset abandons any message in flight.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
    end
  end

  // Next-state logic. Every exit into a waiting or terminal state reloads
  // the round counter with zero, so round_o already reads 0 there; exits
  // into a permutation load that permutation's first round.
  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    rndLoad      = 1'b0;
    rndLoadValue = ROUND_A_FIRST;
    rndCountEn   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = INIT;
          blk_d   = '0;
          rndLoad = 1'b1;
        end
      end
      INIT: begin
        if (lastRound) begin
          state_d = WAIT_AD;
          rndLoad = 1'b1;
        end else begin
          rndCountEn = 1'b1;
        end
      end
      WAIT_AD: begin
        if (data_valid_i) begin
          state_d      = AD;
          rndLoad      = 1'b1;
          rndLoadValue = ROUND_B_FIRST;
        end
      end
      AD: begin
        if (lastRound) begin
          state_d = WAIT_PT;
          rndLoad = 1'b1;
        end else begin
          rndCountEn = 1'b1;
        end
      end
      WAIT_PT: begin
        if (data_valid_i) begin
          rndLoad = 1'b1;
          if (blk_q < LAST_BLOCK) begin
            state_d      = PT;
            rndLoadValue = ROUND_B_FIRST;
          end else begin
            state_d = FINAL;
          end
        end
      end
      PT: begin
        if (lastRound) begin
          state_d = WAIT_PT;
          blk_d   = blk_q + 4'd1;
          rndLoad = 1'b1;
        end else begin
          rndCountEn = 1'b1;
        end
      end
      FINAL: begin
        if (lastRound) begin
          state_d = DONE;
          rndLoad = 1'b1;
        end else begin
          rndCountEn = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        rndLoad = 1'b1;
      end
    endcase
  end

  // Moore output decode of (state, round). The last PT block is absorbed by
  // FINAL, which is why FINAL round 0 also fires the data XOR and cipher
  // capture together with the key XOR at the permutation input.
  always_comb begin
    data_ready_o    = 1'b0;
    round_o         = '0;
    selectionp_o    = 1'b0;
    enable_o        = 1'b0;
    en_xor_data_b_o = 1'b0;
    en_xor_key_b_o  = 1'b0;
    en_xor_key_e_o  = 1'b0;
    en_xor_lsb_e_o  = 1'b0;
    en_cipher_o     = 1'b0;
    en_tag_o        = 1'b0;
    done_o          = 1'b0;
    block_o         = blk_q;
    case (state_q)
      INIT: begin
        round_o        = rnd;
        enable_o       = 1'b1;
        selectionp_o   = (rnd != ROUND_A_FIRST);
        en_xor_key_e_o = lastRound;
      end
      WAIT_AD, WAIT_PT: begin
        data_ready_o = 1'b1;
      end
      AD: begin
        round_o         = rnd;
        enable_o        = 1'b1;
        selectionp_o    = 1'b1;
        en_xor_data_b_o = (rnd == ROUND_B_FIRST);
        en_xor_lsb_e_o  = lastRound;
      end
      PT: begin
        round_o         = rnd;
        enable_o        = 1'b1;
        selectionp_o    = 1'b1;
        en_xor_data_b_o = (rnd == ROUND_B_FIRST);
        en_cipher_o     = (rnd == ROUND_B_FIRST);
      end
      FINAL: begin
        round_o         = rnd;
        enable_o        = 1'b1;
        selectionp_o    = 1'b1;
        en_xor_data_b_o = (rnd == ROUND_A_FIRST);
        en_xor_key_b_o  = (rnd == ROUND_A_FIRST);
        en_cipher_o     = (rnd == ROUND_A_FIRST);
        en_xor_key_e_o  = lastRound;
        en_tag_o        = lastRound;
      end
      DONE: begin
        done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// tb_ascon_ctrl_fsm
// Scoreboard bench for ascon_ctrl_fsm. Two instances: NB_BLOCKS=4 and
// NB_BLOCKS=1. Stimulus pushes the expected output vector for each cycle;
// a monitor pops and compares it on the falling edge.
module tb_ascon_ctrl_fsm;

  logic clock = 1'b0;
  logic reset;
  logic start4, valid4, start1, valid1;

  logic       ready4, sel4, en4, xdb4, xkb4, xke4, xle4, ciph4, tag4, done4;
  logic [3:0] round4, block4;
  logic       ready1, sel1, en1, xdb1, xkb1, xke1, xle1, ciph1, tag1, done1;
  logic [3:0] round1, block1;

  logic [17:0] outVec4, outVec1;
  logic [17:0] expQ[$];

  int   testsRun = 0;
  int   testsFailed = 0;
  logic scoreOn = 1'b0;
  logic monSel = 1'b0;
  int   cycleCnt = 0;
  int   cipherCount = 0;
  int   tagCount = 0;
  int   doneCycle = -1;
  int   startCycle = 0;

  always #50 clock = ~clock;

  ascon_ctrl_fsm #(.NB_BLOCKS(4)) dut4 (
    .clock_i         (clock),
    .reset_i         (reset),
    .start_i         (start4),
    .data_valid_i    (valid4),
    .data_ready_o    (ready4),
    .round_o         (round4),
    .selectionp_o    (sel4),
    .enable_o        (en4),
    .en_xor_data_b_o (xdb4),
    .en_xor_key_b_o  (xkb4),
    .en_xor_key_e_o  (xke4),
    .en_xor_lsb_e_o  (xle4),
    .en_cipher_o     (ciph4),
    .en_tag_o        (tag4),
    .block_o         (block4),
    .done_o          (done4)
  );

  ascon_ctrl_fsm #(.NB_BLOCKS(1)) dut1 (
    .clock_i         (clock),
    .reset_i         (reset),
    .start_i         (start1),
    .data_valid_i    (valid1),
    .data_ready_o    (ready1),
    .round_o         (round1),
    .selectionp_o    (sel1),
    .enable_o        (en1),
    .en_xor_data_b_o (xdb1),
    .en_xor_key_b_o  (xkb1),
    .en_xor_key_e_o  (xke1),
    .en_xor_lsb_e_o  (xle1),
    .en_cipher_o     (ciph1),
    .en_tag_o        (tag1),
    .block_o         (block1),
    .done_o          (done1)
  );

  assign outVec4 = {round4, block4, sel4, en4, xdb4, xkb4, xke4, xle4, ciph4, tag4, ready4, done4};
  assign outVec1 = {round1, block1, sel1, en1, xdb1, xkb1, xke1, xle1, ciph1, tag1, ready1, done1};

  // Output vector layout: {round, block, sel, en, xdb, xkb, xke, xle, cipher, tag, ready, done}
  function automatic logic [17:0] mk(input logic [3:0] rnd, input logic [3:0] blk,
                                     input logic sel, input logic en, input logic xdb,
                                     input logic xkb, input logic xke, input logic xle,
                                     input logic ciph, input logic tag, input logic rdy,
                                     input logic dn);
    return {rnd, blk, sel, en, xdb, xkb, xke, xle, ciph, tag, rdy, dn};
  endfunction

  function automatic logic [17:0] expInit(input int r);
    return mk(4'(r), 4'd0, r != 0, 1'b1, 1'b0, 1'b0, r == 11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [17:0] expWait(input int b);
    return mk(4'd0, 4'(b), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic logic [17:0] expAd(input int r);
    return mk(4'(r), 4'd0, 1'b1, 1'b1, r == 6, 1'b0, 1'b0, r == 11, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [17:0] expPt(input int r, input int b);
    return mk(4'(r), 4'(b), 1'b1, 1'b1, r == 6, 1'b0, 1'b0, 1'b0, r == 6, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [17:0] expFinal(input int r, input int b);
    return mk(4'(r), 4'(b), 1'b1, 1'b1, r == 0, r == 0, r == 11, 1'b0, r == 0, r == 11, 1'b0, 1'b0);
  endfunction

  function automatic logic [17:0] expDone(input int b);
    return mk(4'd0, 4'(b), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic checkOutput(input string name, input int got, input int want);
    testsRun++;
    if (got !== want) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Drive one cycle of inputs to the selected instance and queue the
  // outputs expected after the coming rising edge.
  task automatic applyStimulus(input logic st, input logic dv, input logic [17:0] expVec);
    @(negedge clock);
    #1;
    scoreOn = 1'b1;
    start4  = monSel ? 1'b0 : st;
    valid4  = monSel ? 1'b0 : dv;
    start1  = monSel ? st : 1'b0;
    valid1  = monSel ? dv : 1'b0;
    expQ.push_back(expVec);
  endtask

  task automatic finishScore();
    @(negedge clock);
    #1;
    scoreOn = 1'b0;
    start4  = 1'b0;
    valid4  = 1'b0;
    start1  = 1'b0;
    valid1  = 1'b0;
  endtask

  // Scoreboard monitor: one expected vector per falling edge while scoring.
  initial begin
    logic [17:0] want;
    forever begin
      @(negedge clock);
      if (scoreOn) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL scoreboard underflow at cycle %0d", cycleCnt);
        end else begin
          want = expQ.pop_front();
          checkOutput(monSel ? "nb1 outputs" : "nb4 outputs",
                      int'(monSel ? outVec1 : outVec4), int'(want));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      cycleCnt++;
    end
  end

  // Pulse counters and done-rise timestamp for the selected instance.
  initial begin
    forever begin
      @(negedge clock);
      if (monSel ? ciph1 : ciph4) cipherCount++;
      if (monSel ? tag1 : tag4) tagCount++;
      if ((monSel ? done1 : done4) && doneCycle < 0) doneCycle = cycleCnt;
    end
  end

  initial begin
    reset  = 1'b0;
    start4 = 1'b0;
    valid4 = 1'b0;
    start1 = 1'b0;
    valid1 = 1'b0;
    #1 reset = 1'b1;
    #9;
    checkOutput("reset nb4", int'(outVec4), 0);
    checkOutput("reset nb1", int'(outVec1), 0);
    #15 reset = 1'b0;
    #5;
    checkOutput("post-reset nb4", int'(outVec4), 0);
    checkOutput("post-reset nb1", int'(outVec1), 0);

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 18'd0);

    // Full run, valid tied high
    cipherCount = 0;
    tagCount    = 0;
    doneCycle   = -1;
    applyStimulus(1'b1, 1'b1, expInit(0));
    startCycle = cycleCnt;
    for (int r = 1; r <= 11; r++) applyStimulus(1'b0, 1'b1, expInit(r));
    applyStimulus(1'b0, 1'b1, expWait(0));
    for (int r = 6; r <= 11; r++) applyStimulus(1'b0, 1'b1, expAd(r));
    for (int b = 0; b < 3; b++) begin
      applyStimulus(1'b0, 1'b1, expWait(b));
      for (int r = 6; r <= 11; r++) applyStimulus(1'b0, 1'b1, expPt(r, b));
    end
    applyStimulus(1'b0, 1'b1, expWait(3));
    for (int r = 0; r <= 11; r++) applyStimulus(1'b0, 1'b1, expFinal(r, 3));
    applyStimulus(1'b0, 1'b1, expDone(3));
    applyStimulus(1'b0, 1'b1, expDone(3));
    checkOutput("cipher pulses nb4", cipherCount, 4);
    checkOutput("tag pulses nb4", tagCount, 1);
    checkOutput("done latency", doneCycle - (startCycle + 1), 53);

    // Start held in DONE, start during INIT/AD ignored, stall in WAIT_PT
    applyStimulus(1'b1, 1'b1, expInit(0));
    applyStimulus(1'b1, 1'b1, expInit(1));
    for (int r = 2; r <= 11; r++) applyStimulus(1'b0, 1'b1, expInit(r));
    applyStimulus(1'b0, 1'b1, expWait(0));
    for (int r = 6; r <= 11; r++) applyStimulus(r == 8, 1'b1, expAd(r));
    applyStimulus(1'b0, 1'b1, expWait(0));
    for (int r = 6; r <= 11; r++) applyStimulus(1'b0, 1'b1, expPt(r, 0));
    applyStimulus(1'b0, 1'b1, expWait(1));
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, expWait(1));
    for (int r = 6; r <= 11; r++) applyStimulus(1'b0, 1'b1, expPt(r, 1));
    applyStimulus(1'b0, 1'b1, expWait(2));
    for (int r = 6; r <= 8; r++) applyStimulus(1'b0, 1'b1, expPt(r, 2));
    finishScore();

    // Reset at PT round 8 of block 2, between edges
    reset = 1'b1;
    #1;
    checkOutput("async reset mid-PT", int'(outVec4), 0);
    @(posedge clock);
    #1;
    checkOutput("reset held", int'(outVec4), 0);
    #10 reset = 1'b0;

    // Restart after reset
    applyStimulus(1'b1, 1'b0, expInit(0));
    for (int r = 1; r <= 11; r++) applyStimulus(1'b0, 1'b0, expInit(r));
    applyStimulus(1'b0, 1'b0, expWait(0));
    applyStimulus(1'b0, 1'b0, expWait(0));
    finishScore();

    // NB_BLOCKS = 1: WAIT_PT goes straight to FINAL
    monSel      = 1'b1;
    cipherCount = 0;
    tagCount    = 0;
    doneCycle   = -1;
    applyStimulus(1'b1, 1'b1, expInit(0));
    for (int r = 1; r <= 11; r++) applyStimulus(1'b0, 1'b1, expInit(r));
    applyStimulus(1'b0, 1'b1, expWait(0));
    for (int r = 6; r <= 11; r++) applyStimulus(1'b0, 1'b1, expAd(r));
    applyStimulus(1'b0, 1'b1, expWait(0));
    for (int r = 0; r <= 11; r++) applyStimulus(1'b0, 1'b1, expFinal(r, 0));
    applyStimulus(1'b0, 1'b1, expDone(0));
    applyStimulus(1'b0, 1'b0, expDone(0));
    finishScore();
    checkOutput("cipher pulses nb1", cipherCount, 1);
    checkOutput("tag pulses nb1", tagCount, 1);

    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
